// File: rtl/sgmii_pcs_cfg.sv
// SGMII PCS configuration sequencer: waits out startup, writes the init
// registers, then polls PCS status and serves host register accesses.
module sgmii_pcs_cfg #(
  parameter int unsigned STARTUP_CYCLES = 16,
  parameter int unsigned POLL_INTERVAL  = 125000,
  parameter int unsigned BUSY_TIMEOUT   = 1023,
  parameter logic [15:0] IF_MODE_VAL    = 16'h0003,
  parameter logic [15:0] LINK_TMR_LO    = 16'h0D40,
  parameter logic [15:0] LINK_TMR_HI    = 16'h0003,
  parameter logic [15:0] CTRL_VAL       = 16'h1340
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [15:0] reg_data_in,
  input  logic [15:0] reg_data_out,
  input  logic        reg_busy,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        cfg_done,
  output logic        link_up,
  output logic        an_complete,
  output logic        timeout_err
);

  localparam int unsigned SW = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned PW = $clog2(POLL_INTERVAL + 1);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STARTUP_CYCLES - 1);
  localparam logic [PW-1:0] PI_LAST = PW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {STARTUP, INIT, DONE_IDLE, POLL_RD, HOST_ACC} state_e;

  state_e      state_q, state_d;
  logic [SW-1:0] st_cnt_q, st_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic        pend_q, pend_d;
  logic [TW-1:0] wait_q, wait_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        hwr_q, hwr_d;
  logic [4:0]  haddr_q, haddr_d;
  logic [15:0] hwdata_q, hwdata_d;
  logic        ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d, link_q, link_d, an_q, an_d, terr_q, terr_d;

  logic        strobe, timeout_hit, acc_end, wrap;
  logic [15:0] acc_data;
  logic [4:0]  init_addr;
  logic [15:0] init_data;

  // A timed-out access completes like a normal one but returns zero data.
  assign strobe      = rd_q | wr_q;
  assign timeout_hit = strobe & reg_busy & (wait_q == TO_LAST);
  assign acc_end     = strobe & (~reg_busy | timeout_hit);
  assign acc_data    = (strobe & ~reg_busy) ? reg_data_out : '0;

  // Init write table indexed by the init step.
  always_comb begin
    init_addr = 5'h00;
    init_data = CTRL_VAL;
    case (idx_q)
      2'd0:    begin init_addr = 5'h14; init_data = IF_MODE_VAL; end
      2'd1:    begin init_addr = 5'h12; init_data = LINK_TMR_LO; end
      2'd2:    begin init_addr = 5'h13; init_data = LINK_TMR_HI; end
      default: begin init_addr = 5'h00; init_data = CTRL_VAL;    end
    endcase
  end

  // Next-state, strobe, poll scheduling and status updates.
  always_comb begin
    state_d    = state_q;
    st_cnt_d   = st_cnt_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    pend_d     = pend_q;
    wait_d     = '0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hwr_d      = hwr_q;
    haddr_d    = haddr_q;
    hwdata_d   = hwdata_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    done_d     = done_q;
    link_d     = link_q;
    an_d       = an_q;
    terr_d     = terr_q;
    wrap       = 1'b0;

    if (strobe && reg_busy && !timeout_hit) wait_d = wait_q + TW'(1);
    if (acc_end) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end
    if (timeout_hit) terr_d = 1'b1;

    if (state_q != STARTUP && state_q != INIT) begin
      if (poll_cnt_q == PI_LAST) begin
        poll_cnt_d = '0;
        wrap       = 1'b1;
      end else begin
        poll_cnt_d = poll_cnt_q + PW'(1);
      end
    end
    // A wrap coinciding with a poll start re-arms the pending flag.
    pend_d = pend_q | wrap;

    case (state_q)
      STARTUP: begin
        if (st_cnt_q == ST_LAST) begin
          st_cnt_d = '0;
          state_d  = INIT;
        end else begin
          st_cnt_d = st_cnt_q + SW'(1);
        end
      end
      INIT: begin
        if (!strobe) begin
          wr_d    = 1'b1;
          addr_d  = init_addr;
          wdata_d = init_data;
        end else if (acc_end) begin
          if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = DONE_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      DONE_IDLE: begin
        // The ack cycle is skipped so a host still holding req is not re-served.
        if (host_req && !ack_q) begin
          hwr_d    = host_wr;
          haddr_d  = host_addr;
          hwdata_d = host_wdata;
          state_d  = HOST_ACC;
        end else if (pend_q) begin
          pend_d  = wrap;
          state_d = POLL_RD;
        end
      end
      POLL_RD: begin
        if (!strobe) begin
          rd_d   = 1'b1;
          addr_d = 5'h01;
        end else if (acc_end) begin
          link_d  = acc_data[2];
          an_d    = acc_data[5];
          state_d = DONE_IDLE;
        end
      end
      HOST_ACC: begin
        if (!strobe) begin
          rd_d    = ~hwr_q;
          wr_d    = hwr_q;
          addr_d  = haddr_q;
          wdata_d = hwdata_q;
        end else if (acc_end) begin
          ack_d   = 1'b1;
          rdata_d = hwr_q ? '0 : acc_data;
          state_d = DONE_IDLE;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STARTUP;
      st_cnt_q   <= '0;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      pend_q     <= 1'b0;
      wait_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hwr_q      <= 1'b0;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      link_q     <= 1'b0;
      an_q       <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_cnt_q   <= st_cnt_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      pend_q     <= pend_d;
      wait_q     <= wait_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hwr_q      <= hwr_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      link_q     <= link_d;
      an_q       <= an_d;
      terr_q     <= terr_d;
    end
  end

  assign reg_addr    = addr_q;
  assign reg_rd      = rd_q;
  assign reg_wr      = wr_q;
  assign reg_data_in = wdata_q;
  assign host_ack    = ack_q;
  assign host_rdata  = rdata_q;
  assign cfg_done    = done_q;
  assign link_up     = link_q;
  assign an_complete = an_q;
  assign timeout_err = terr_q;

endmodule
